// File: rtl/jk_ff_bank_arbiter_if.sv
// Requester-side command bus for the JK flop bank arbiter.
// Requesters drive valid/op/idx; the arbiter answers with a one-hot ready.
interface jk_ff_bank_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 3
);
  logic [N_REQ-1:0]       req_valid;
  logic [2*N_REQ-1:0]     req_op;
  logic [IDX_W*N_REQ-1:0] req_idx;
  logic [N_REQ-1:0]       req_ready;

  modport master (output req_valid, req_op, req_idx, input req_ready);
  modport slave  (input req_valid, req_op, req_idx, output req_ready);
endinterface

// File: rtl/jk_ff_bank_arbiter.sv
// Round-robin arbiter sharing a bank of JK flops between several requesters.
// One command is applied per grant, followed by a programmable idle gap.
module jk_ff_bank_arbiter #(
  parameter int N_REQ      = 4,
  parameter int NUM_FF     = 8,
  parameter int IDX_W      = 3,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  jk_ff_bank_arbiter_if.slave      bus,
  output logic [NUM_FF-1:0]        q,
  output logic                     apply_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     err_idx,
  output logic                     busy
);
  localparam int GID_W = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state;
  logic [GID_W-1:0] rr_ptr;
  logic [GID_W-1:0] sel;
  logic             found;
  logic [GID_W:0]   cand;
  logic [1:0]       op_sel;
  logic [IDX_W-1:0] idx_sel;
  logic [1:0]       op_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [3:0]       gap_cnt;
  logic             hs;
  logic             idx_ok;

  function automatic logic jk_next(input logic qc, input logic j, input logic k);
    case ({j, k})
      2'b00:   return qc;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~qc;
    endcase
  endfunction

  // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    sel           = '0;
    found         = 1'b0;
    cand          = '0;
    op_sel        = '0;
    idx_sel       = '0;
    bus.req_ready = '0;
    if (state == S_IDLE) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (GID_W+1)'(k);
        if (cand >= (GID_W+1)'(N_REQ)) cand = cand - (GID_W+1)'(N_REQ);
        if (!found && bus.req_valid[cand[GID_W-1:0]]) begin
          found = 1'b1;
          sel   = cand[GID_W-1:0];
        end
      end
      if (found) bus.req_ready[sel] = 1'b1;
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (sel == GID_W'(k)) begin
        op_sel  = bus.req_op[2*k +: 2];
        idx_sel = bus.req_idx[IDX_W*k +: IDX_W];
      end
    end
  end

  assign hs          = found;
  assign apply_valid = (state == S_APPLY);
  assign idx_ok      = (32'(idx_p0) < NUM_FF);
  assign err_idx     = apply_valid && !idx_ok;
  assign busy        = (state != S_IDLE);

  // Stage p0: command captured at the handshake, consumed in APPLY.
  always_ff @(posedge clk) begin
    if (hs) begin
      op_p0  <= op_sel;
      idx_p0 <= idx_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      gap_cnt  <= '0;
      q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            grant_id <= sel;
            rr_ptr   <= (sel == GID_W'(N_REQ-1)) ? '0 : sel + 1'b1;
            state    <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (idx_ok) begin
            for (int i = 0; i < NUM_FF; i++) begin
              if (idx_p0 == IDX_W'(i)) q[i] <= jk_next(q[i], op_p0[1], op_p0[0]);
            end
          end
          if (GAP_CYCLES > 0) begin
            gap_cnt <= 4'(GAP_CYCLES - 1);
            state   <= S_GAP;
          end else begin
            state   <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) state <= S_IDLE;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jk_ff_bank_arbiter.sv
// Scoreboard bench for jk_ff_bank_arbiter: an 8-flop instance for traffic and a
// 6-flop instance for out-of-range indices.
module tb_jk_ff_bank_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jk_ff_bank_arbiter_if #(.N_REQ(4), .IDX_W(3)) ifa ();
  jk_ff_bank_arbiter_if #(.N_REQ(4), .IDX_W(3)) ifb ();

  logic [7:0] qa;
  logic [5:0] qb;
  logic       apa, erra, busya, apb, errb, busyb;
  logic [1:0] gida, gidb;

  jk_ff_bank_arbiter #(.N_REQ(4), .NUM_FF(8), .IDX_W(3), .GAP_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .q(qa), .apply_valid(apa),
    .grant_id(gida), .err_idx(erra), .busy(busya));

  jk_ff_bank_arbiter #(.N_REQ(4), .NUM_FF(6), .IDX_W(3), .GAP_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .q(qb), .apply_valid(apb),
    .grant_id(gidb), .err_idx(errb), .busy(busyb));

  typedef struct { int gid; logic [7:0] q_before; logic [7:0] q_after; } exp_t;
  typedef struct { int rid; logic [1:0] op; logic [2:0] idx; } cmd_t;

  exp_t sb[$];
  cmd_t pend[$];
  int   order[$];
  int   apply_cyc[$];
  logic [7:0] q_m;
  int   rr_m;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [3:0] predict(input logic [3:0] v, input int rr);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (rr + k) % 4;
      if (v[i]) return 4'(1 << i);
    end
    return 4'b0;
  endfunction

  function automatic logic jk_model(input logic qc, input logic [1:0] op);
    case (op)
      2'b00:   return qc;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~qc;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    ifa.req_valid = '0; ifa.req_op = '0; ifa.req_idx = '0;
    ifb.req_valid = '0; ifb.req_op = '0; ifb.req_idx = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q_m = '0; rr_m = 0;
    sb.delete(); pend.delete(); order.delete(); apply_cyc.delete();
  endtask

  // Drives queued commands on instance A and scores every cycle against the model.
  task automatic run_traffic(input int max_cycles);
    int cnt, cyc, r, jsel;
    bit done;
    exp_t cur;
    logic [3:0] v, er;
    logic [7:0] q_prev;
    cnt = 0; cyc = 0; done = 0;
    cur = '{0, 8'h00, 8'h00};
    while (!done) begin
      v = '0;
      for (int rq = 0; rq < 4; rq++) begin
        for (int j = 0; j < pend.size(); j++) begin
          if (pend[j].rid == rq) begin
            v[rq] = 1'b1;
            ifa.req_op[2*rq +: 2]  = pend[j].op;
            ifa.req_idx[3*rq +: 3] = pend[j].idx;
            break;
          end
        end
      end
      ifa.req_valid = v;
      @(negedge clk);
      er = (cnt == 0) ? predict(v, rr_m) : 4'b0;
      checks++;
      if (ifa.req_ready !== er) begin errors++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, ifa.req_ready, er); end
      checks++;
      if (busya !== (cnt != 0)) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busya, cnt != 0); end
      checks++;
      if (apa !== (cnt == 2)) begin errors++; $display("FAIL apply_valid cyc=%0d got=%b exp=%b", cyc, apa, cnt == 2); end
      if (cnt == 2) begin
        if (sb.size() == 0) begin errors++; $display("FAIL scoreboard_underflow cyc=%0d", cyc); end
        else cur = sb.pop_front();
        apply_cyc.push_back(cyc);
        checks++;
        if (gida !== 2'(cur.gid)) begin errors++; $display("FAIL grant_id got=%0d exp=%0d", gida, cur.gid); end
        checks++;
        if (qa !== cur.q_before) begin errors++; $display("FAIL q_in_apply got=%h exp=%h", qa, cur.q_before); end
        checks++;
        if (erra !== 1'b0) begin errors++; $display("FAIL err_idx got=%b exp=0", erra); end
      end else if (cnt == 1) begin
        checks++;
        if (qa !== cur.q_after) begin errors++; $display("FAIL q_after_apply got=%h exp=%h", qa, cur.q_after); end
      end else begin
        checks++;
        if (qa !== q_m) begin errors++; $display("FAIL q_idle got=%h exp=%h", qa, q_m); end
      end
      if (cnt > 0) cnt--;
      else if (er != 4'b0) begin
        r = 0;
        for (int k = 0; k < 4; k++) if (er[k]) r = k;
        jsel = 0;
        for (int j = pend.size() - 1; j >= 0; j--) if (pend[j].rid == r) jsel = j;
        q_prev = q_m;
        q_m[pend[jsel].idx] = jk_model(q_m[pend[jsel].idx], pend[jsel].op);
        sb.push_back('{r, q_prev, q_m});
        pend.delete(jsel);
        order.push_back(r);
        rr_m = (r + 1) % 4;
        cnt = 2;
      end
      cyc++;
      if (pend.size() == 0 && cnt == 0 && sb.size() == 0) done = 1;
      else if (cyc >= max_cycles) begin
        errors++; $display("FAIL traffic_timeout pending=%0d sb=%0d", pend.size(), sb.size());
        done = 1;
      end
      @(posedge clk); #1;
    end
    ifa.req_valid = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.req_valid = '0; ifa.req_op = '0; ifa.req_idx = '0;
    ifb.req_valid = '0; ifb.req_op = '0; ifb.req_idx = '0;
    #12;
    checks++;
    if (qa !== 8'h00 || busya !== 1'b0 || apa !== 1'b0 || erra !== 1'b0 || gida !== 2'd0)
      begin errors++; $display("FAIL reset_state q=%h busy=%b apply=%b err=%b gid=%0d exp 00/0/0/0/0", qa, busya, apa, erra, gida); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (qa !== 8'h00 || busya !== 1'b0 || ifa.req_ready !== 4'b0)
        begin errors++; $display("FAIL idle_after_reset cyc=%0d q=%h busy=%b ready=%b exp 00/0/0000", i, qa, busya, ifa.req_ready); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_set_toggle();
    do_reset();
    pend.push_back('{0, 2'b10, 3'd3});
    pend.push_back('{0, 2'b11, 3'd3});
    pend.push_back('{0, 2'b11, 3'd3});
    run_traffic(60);
    checks++;
    if (apply_cyc.size() != 3) begin errors++; $display("FAIL single_apply_count got=%0d exp=3", apply_cyc.size()); end
    else begin
      checks++;
      if (apply_cyc[1] - apply_cyc[0] != 3 || apply_cyc[2] - apply_cyc[1] != 3)
        begin errors++; $display("FAIL apply_spacing got=%0d,%0d exp=3,3", apply_cyc[1] - apply_cyc[0], apply_cyc[2] - apply_cyc[1]); end
    end
    @(negedge clk);
    checks++;
    if (qa !== 8'h08) begin errors++; $display("FAIL single_final_q got=%h exp=08", qa); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 4; r++) pend.push_back('{r, 2'b10, 3'(r)});
    run_traffic(60);
    checks++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3)
      begin errors++; $display("FAIL rr_order got=%p exp=0,1,2,3", order); end
    @(negedge clk);
    checks++;
    if (qa !== 8'h0F) begin errors++; $display("FAIL rr_final_q got=%h exp=0f", qa); end
    checks++;
    if (gida !== 2'd3) begin errors++; $display("FAIL rr_grant_hold got=%0d exp=3", gida); end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness_wrap();
    do_reset();
    pend.push_back('{1, 2'b10, 3'd0});
    pend.push_back('{3, 2'b00, 3'd7});
    pend.push_back('{1, 2'b10, 3'd1});
    pend.push_back('{3, 2'b10, 3'd2});
    run_traffic(80);
    checks++;
    if (order.size() != 4 || order[0] != 1 || order[1] != 3 || order[2] != 1 || order[3] != 3)
      begin errors++; $display("FAIL wrap_order got=%p exp=1,3,1,3", order); end
    @(negedge clk);
    checks++;
    if (qa !== 8'h07) begin errors++; $display("FAIL wrap_final_q got=%h exp=07", qa); end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_index();
    do_reset();
    ifb.req_valid = 4'b0001; ifb.req_op[1:0] = 2'b10; ifb.req_idx[2:0] = 3'd7;
    @(negedge clk);
    checks++;
    if (ifb.req_ready !== 4'b0001) begin errors++; $display("FAIL bad_ready got=%b exp=0001", ifb.req_ready); end
    @(posedge clk); #1 ifb.req_valid = '0;
    @(negedge clk);
    checks++;
    if (apb !== 1'b1 || errb !== 1'b1) begin errors++; $display("FAIL err_pulse apply=%b err=%b exp 1/1", apb, errb); end
    @(negedge clk);
    checks++;
    if (errb !== 1'b0 || qb !== 6'h00 || busyb !== 1'b1) begin errors++; $display("FAIL err_after err=%b q=%h busy=%b exp 0/00/1", errb, qb, busyb); end
    @(posedge clk); #1;
    ifb.req_valid = 4'b0010; ifb.req_op[3:2] = 2'b10; ifb.req_idx[5:3] = 3'd5;
    @(negedge clk);
    checks++;
    if (ifb.req_ready !== 4'b0010) begin errors++; $display("FAIL good_ready got=%b exp=0010", ifb.req_ready); end
    @(posedge clk); #1 ifb.req_valid = '0;
    @(negedge clk);
    checks++;
    if (errb !== 1'b0 || gidb !== 2'd1) begin errors++; $display("FAIL good_apply err=%b gid=%0d exp 0/1", errb, gidb); end
    @(negedge clk);
    checks++;
    if (qb !== 6'h20) begin errors++; $display("FAIL good_q got=%h exp=20", qb); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    do_reset();
    pend.push_back('{0, 2'b10, 3'd2});
    run_traffic(30);
    ifa.req_valid = 4'b0010; ifa.req_op[3:2] = 2'b10; ifa.req_idx[5:3] = 3'd5;
    @(negedge clk);
    checks++;
    if (ifa.req_ready !== 4'b0010) begin errors++; $display("FAIL ar_ready got=%b exp=0010", ifa.req_ready); end
    @(posedge clk); #1 ifa.req_valid = '0;
    @(negedge clk);
    checks++;
    if (apa !== 1'b1 || qa !== 8'h04) begin errors++; $display("FAIL ar_in_apply apply=%b q=%h exp 1/04", apa, qa); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (qa !== 8'h00 || busya !== 1'b0 || apa !== 1'b0 || gida !== 2'd0)
      begin errors++; $display("FAIL ar_immediate q=%h busy=%b apply=%b gid=%0d exp 00/0/0/0", qa, busya, apa, gida); end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (qa[5] !== 1'b0 || qa !== 8'h00 || busya !== 1'b0)
        begin errors++; $display("FAIL ar_after_release cyc=%0d q=%h busy=%b exp 00/0", i, qa, busya); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_set_toggle();
    test_round_robin();
    test_fairness_wrap();
    test_bad_index();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
